// File: rtl/song_recorder_pkg.sv
// rtl/song_recorder_pkg.sv - shared sizes and FSM state type for the song recorder
package recorder_pkg;

  localparam int NOTE_W = 5;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RECORD = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/song_recorder_if.sv
// rtl/song_recorder_if.sv - control, button and playback signals of the song recorder
interface song_recorder_if #(
  parameter int NOTE_W = recorder_pkg::NOTE_W,
  parameter int DEPTH  = recorder_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
);

  logic              beat;
  logic              rec_start;
  logic              rec_stop;
  logic [NOTE_W-1:0] button;
  logic [ADDR_W-1:0] rd_addr;
  logic [NOTE_W-1:0] rd_data;
  logic              recording;
  logic [ADDR_W:0]   length;
  logic              full;

  // driver side: sequencer / player
  modport master (
    output beat, rec_start, rec_stop, button, rd_addr,
    input  rd_data, recording, length, full
  );

  // recorder side
  modport slave (
    input  beat, rec_start, rec_stop, button, rd_addr,
    output rd_data, recording, length, full
  );

endinterface

// File: rtl/song_recorder_step_capture.sv
// rtl/song_recorder_step_capture.sv - OR-accumulator catching button presses within one step
module step_capture #(
  parameter int W = recorder_pkg::NOTE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] button,
  output logic [W-1:0] acc
);

  // clear wins over accumulate so a step boundary starts from an empty pattern
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc | button;
    end
  end

endmodule

// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records per-step button patterns into a song memory and plays them back
module song_recorder
  import recorder_pkg::state_t, recorder_pkg::IDLE, recorder_pkg::ARMED,
         recorder_pkg::RECORD, recorder_pkg::DONE;
#(
  parameter int NOTE_W = recorder_pkg::NOTE_W,
  parameter int DEPTH  = recorder_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  song_recorder_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   length;
  logic              full;
  logic [NOTE_W-1:0] acc;
  logic [NOTE_W-1:0] rd_data;
  logic [NOTE_W-1:0] mem [DEPTH];

  logic start_ok;
  logic wr_en;
  logic acc_clear;
  logic acc_enable;
  logic recording;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: rec_stop outranks beat in ARMED, a write on the last slot ends the take
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (bus.rec_start) state_next = ARMED;
      end
      ARMED: begin
        if (bus.rec_stop)  state_next = IDLE;
        else if (bus.beat) state_next = RECORD;
      end
      RECORD: begin
        if (bus.rec_stop || (bus.beat && wptr == LAST_ADDR)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // output decode: recording flag plus datapath strobes
  always_comb begin
    recording  = 1'b0;
    start_ok   = 1'b0;
    wr_en      = 1'b0;
    acc_clear  = 1'b0;
    acc_enable = 1'b0;
    case (state)
      IDLE, DONE: begin
        start_ok  = bus.rec_start;
        acc_clear = bus.rec_start;
      end
      ARMED: begin
        recording = 1'b1;
        acc_clear = bus.beat & ~bus.rec_stop;
      end
      RECORD: begin
        recording  = 1'b1;
        acc_enable = 1'b1;
        wr_en      = bus.beat;
        acc_clear  = bus.beat | bus.rec_stop;
      end
      default: ;
    endcase
  end

  step_capture #(.W(NOTE_W)) u_capture (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .enable (acc_enable),
    .button (bus.button),
    .acc    (acc)
  );

  // write pointer, step count and full flag; cleared when a new take is armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      length <= '0;
      full   <= 1'b0;
    end else if (start_ok) begin
      wptr   <= '0;
      length <= '0;
      full   <= 1'b0;
    end else if (wr_en) begin
      wptr   <= wptr + ADDR_W'(1);
      length <= length + (ADDR_W + 1)'(1);
      if (wptr == LAST_ADDR) full <= 1'b1;
    end
  end

  // song memory write port; contents survive reset and are masked by length
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= acc | bus.button;
    end
  end

  // registered read port; steps at or beyond length read as silence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if ({1'b0, bus.rd_addr} < length) begin
      rd_data <= mem[bus.rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.recording = recording;
  assign bus.length    = length;
  assign bus.full      = full;

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - directed self-checking bench for song_recorder
module tb_song_recorder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  song_recorder_if bus ();

  song_recorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle before driving or sampling
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    bus.rec_start = 1'b1; cyc(); bus.rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.rec_stop = 1'b1; cyc(); bus.rec_stop = 1'b0;
  endtask

  task automatic pulse_beat();
    bus.beat = 1'b1; cyc(); bus.beat = 1'b0;
  endtask

  task automatic read_at(input int a, input logic [4:0] exp, input string tag);
    bus.rd_addr = 7'(a);
    cyc();
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.beat = 1'b0;
    bus.rec_start = 1'b0;
    bus.rec_stop = 1'b0;
    bus.button = 5'b0;
    bus.rd_addr = 7'd0;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    chk("reset_recording", 32'(bus.recording), 32'd0);
    chk("reset_length", 32'(bus.length), 32'd0);
    chk("reset_full", 32'(bus.full), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);

    // beat and rec_stop in IDLE do nothing
    pulse_beat();
    pulse_stop();
    chk("idle_beat_ignored", 32'(bus.length), 32'd0);
    chk("idle_stop_ignored", 32'(bus.recording), 32'd0);

    // single held press
    pulse_start();
    chk("armed_recording", 32'(bus.recording), 32'd1);
    pulse_beat();
    chk("armed_beat_no_write", 32'(bus.length), 32'd0);
    bus.button = 5'b00001;
    repeat (3) cyc();
    bus.button = 5'b0;
    pulse_beat();
    chk("step0_length", 32'(bus.length), 32'd1);
    read_at(0, 5'b00001, "step0_data");

    // two short presses OR-ed into one step, then an empty step
    bus.button = 5'b00100; cyc();
    bus.button = 5'b10000; cyc();
    bus.button = 5'b00000; cyc();
    pulse_beat();
    pulse_beat();
    chk("steps_length3", 32'(bus.length), 32'd3);
    read_at(1, 5'b10100, "step1_or");
    read_at(2, 5'b00000, "step2_empty");

    // rec_start ignored while recording, rec_stop discards the partial step
    pulse_start();
    chk("start_ignored_rec", 32'(bus.length), 32'd3);
    bus.button = 5'b01000; cyc();
    bus.button = 5'b0;
    pulse_stop();
    chk("stop_alone_length", 32'(bus.length), 32'd3);
    chk("stop_alone_done", 32'(bus.recording), 32'd0);
    read_at(3, 5'b00000, "stop_alone_masked");

    // same again but rec_stop together with beat keeps the step
    pulse_start();
    chk("restart_length0", 32'(bus.length), 32'd0);
    pulse_beat();
    repeat (3) pulse_beat();
    bus.button = 5'b01000; cyc();
    bus.button = 5'b0;
    bus.rec_stop = 1'b1; bus.beat = 1'b1; cyc();
    bus.rec_stop = 1'b0; bus.beat = 1'b0;
    chk("stop_beat_length", 32'(bus.length), 32'd4);
    chk("stop_beat_done", 32'(bus.recording), 32'd0);
    read_at(3, 5'b01000, "stop_beat_data");
    pulse_beat();
    chk("done_beat_ignored", 32'(bus.length), 32'd4);

    // rec_start + rec_stop together in DONE re-arms; rec_stop in ARMED returns to IDLE
    bus.rec_start = 1'b1; bus.rec_stop = 1'b1; cyc();
    bus.rec_start = 1'b0; bus.rec_stop = 1'b0;
    chk("start_stop_armed", 32'(bus.recording), 32'd1);
    chk("start_stop_len0", 32'(bus.length), 32'd0);
    pulse_stop();
    chk("armed_stop_idle", 32'(bus.recording), 32'd0);
    chk("armed_stop_len0", 32'(bus.length), 32'd0);
    read_at(0, 5'b00000, "armed_stop_masked");

    // reset in the middle of a take
    pulse_start();
    pulse_beat();
    for (int s = 0; s < 10; s++) begin
      bus.button = 5'(s + 1);
      pulse_beat();
    end
    bus.button = 5'b0;
    chk("midrec_length10", 32'(bus.length), 32'd10);
    bus.rd_addr = 7'd0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    chk("rst_recording", 32'(bus.recording), 32'd0);
    chk("rst_length", 32'(bus.length), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    read_at(0, 5'b00000, "rst_read_masked");
    pulse_start();
    chk("fresh_armed", 32'(bus.recording), 32'd1);
    pulse_beat();
    bus.button = 5'b00010;
    pulse_beat();
    bus.button = 5'b0;
    chk("fresh_length", 32'(bus.length), 32'd1);
    read_at(0, 5'b00010, "fresh_data");

    // fill all 128 steps
    pulse_stop();
    pulse_start();
    pulse_beat();
    for (int s = 0; s < 128; s++) begin
      if (s == 127) begin
        chk("pre_full_flag", 32'(bus.full), 32'd0);
        chk("pre_full_length", 32'(bus.length), 32'd127);
      end
      bus.button = 5'(s);
      pulse_beat();
    end
    bus.button = 5'b0;
    chk("full_flag", 32'(bus.full), 32'd1);
    chk("full_length", 32'(bus.length), 32'd128);
    chk("full_done", 32'(bus.recording), 32'd0);
    bus.button = 5'b11111;
    pulse_beat();
    bus.button = 5'b0;
    chk("beat129_length", 32'(bus.length), 32'd128);
    read_at(127, 5'b11111, "full_last");
    read_at(0, 5'b00000, "full_first_no_wrap");
    read_at(37, 5'b00101, "full_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
